// File: rtl/dac_scan_ctrl.sv
// Joystick SAR scanner / DAC+mux arbiter; DAC_SCAN_MUTE_EN gates snden off while scanning.
// Latency: idle CPU writes reach dac/sel in 1 cycle; a 4-axis scan takes 24*(SETTLE+1) cycles.
// Backpressure: none; scan_req is ignored while busy, CPU strobes always land in the shadows.
`timescale 1ns/1ps
module dac_scan_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_dac_we,
    input  logic [5:0] cpu_dac,
    input  logic       cpu_sel_we,
    input  logic       cpu_selb,
    input  logic       cpu_sela,
    input  logic       snden_in,
    input  logic       scan_req,
    input  logic       hilo,
    output logic [5:0] dac,
    output logic       selb,
    output logic       sela,
    output logic       snden,
    output logic       busy,
    output logic       done,
    output logic [5:0] axis0,
    output logic [5:0] axis1,
    output logic [5:0] axis2,
    output logic [5:0] axis3
);

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      ax_q, ax_d;
    logic [5:0]      res_q, res_d;
    logic [2:0]      bit_q, bit_d;
    logic [5:0]      dac_q, dac_d;
    logic [1:0]      sel_q, sel_d;
    logic [5:0]      sh_dac_q, sh_dac_d;
    logic [1:0]      sh_sel_q, sh_sel_d;
    logic [3:0][5:0] axis_q, axis_d;
    logic            done_q, done_d;
    logic            snden_q, snden_d;
    logic [5:0]      res_upd;

    always_comb begin
        sh_dac_d = cpu_dac_we ? cpu_dac : sh_dac_q;
        sh_sel_d = cpu_sel_we ? {cpu_selb, cpu_sela} : sh_sel_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        ax_d     = ax_q;
        res_d    = res_q;
        bit_d    = bit_q;
        dac_d    = dac_q;
        sel_d    = sel_q;
        axis_d   = axis_q;
        done_d   = 1'b0;
        res_upd  = res_q;
        if (hilo) begin
            res_upd[bit_q] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Idle outputs follow the shadows, including a write landing this very edge.
                dac_d = sh_dac_d;
                sel_d = sh_sel_d;
                if (scan_req) begin
                    ax_d    = 2'd0;
                    res_d   = 6'd0;
                    bit_d   = 3'd5;
                    sel_d   = 2'd0;
                    dac_d   = 6'd32;
                    cnt_d   = 4'(SETTLE);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (bit_q != 3'd0) begin
                    bit_d   = bit_q - 3'd1;
                    res_d   = res_upd;
                    dac_d   = res_upd | (6'd1 << bit_d);
                    cnt_d   = 4'(SETTLE);
                    state_d = WAIT;
                end else begin
                    axis_d[ax_q] = res_upd;
                    if (ax_q != 2'd3) begin
                        ax_d    = ax_q + 2'd1;
                        sel_d   = ax_d;
                        res_d   = 6'd0;
                        bit_d   = 3'd5;
                        dac_d   = 6'd32;
                        cnt_d   = 4'(SETTLE);
                        state_d = WAIT;
                    end else begin
                        done_d  = 1'b1;
                        dac_d   = sh_dac_d;
                        sel_d   = sh_sel_d;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef DAC_SCAN_MUTE_EN
        // Keep SAR trial codes off the audio path for the whole scan.
        snden_d = (state_d != IDLE) ? 1'b0 : snden_in;
`else
        snden_d = snden_in;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            ax_q     <= 2'd0;
            res_q    <= 6'd0;
            bit_q    <= 3'd0;
            dac_q    <= 6'd0;
            sel_q    <= 2'd0;
            sh_dac_q <= 6'd0;
            sh_sel_q <= 2'd0;
            axis_q   <= '0;
            done_q   <= 1'b0;
            snden_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ax_q     <= ax_d;
            res_q    <= res_d;
            bit_q    <= bit_d;
            dac_q    <= dac_d;
            sel_q    <= sel_d;
            sh_dac_q <= sh_dac_d;
            sh_sel_q <= sh_sel_d;
            axis_q   <= axis_d;
            done_q   <= done_d;
            snden_q  <= snden_d;
        end
    end

    assign dac   = dac_q;
    assign selb  = sel_q[1];
    assign sela  = sel_q[0];
    assign snden = snden_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign axis0 = axis_q[0];
    assign axis1 = axis_q[1];
    assign axis2 = axis_q[2];
    assign axis3 = axis_q[3];

endmodule

// File: tb/tb_dac_scan_ctrl.sv
// Bench for dac_scan_ctrl: comparator model plus SAR reference, directed and random scans.
`timescale 1ns/1ps
module tb_dac_scan_ctrl;

    localparam int S    = 2;
    localparam int SCAN = 24 * (S + 1);

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       cpu_dac_we = 1'b0;
    logic [5:0] cpu_dac = 6'd0;
    logic       cpu_sel_we = 1'b0;
    logic       cpu_selb = 1'b0;
    logic       cpu_sela = 1'b0;
    logic       snden_in = 1'b0;
    logic       scan_req = 1'b0;
    logic       hilo = 1'b0;
    logic [5:0] dac;
    logic       selb, sela, snden, busy, done;
    logic [5:0] axis0, axis1, axis2, axis3;

    int vectors = 0;
    int miscompares = 0;

    logic [5:0] joy [4];
    int         trials[$];
    logic [7:0] prev_sd = 8'd0;
    bit         snd_mon = 1'b0;
    int         snd_bad = 0;

    dac_scan_ctrl #(.SETTLE(S)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_dac_we(cpu_dac_we), .cpu_dac(cpu_dac),
        .cpu_sel_we(cpu_sel_we), .cpu_selb(cpu_selb), .cpu_sela(cpu_sela),
        .snden_in(snden_in), .scan_req(scan_req), .hilo(hilo),
        .dac(dac), .selb(selb), .sela(sela), .snden(snden),
        .busy(busy), .done(done),
        .axis0(axis0), .axis1(axis1), .axis2(axis2), .axis3(axis3)
    );

    always #5 clk = ~clk;

    // Comparator: registered "joystick > DAC" for the axis currently selected.
    always @(posedge clk) hilo <= (joy[{selb, sela}] > dac);

    // Record each distinct trial code presented on axis 2.
    always @(negedge clk) begin
        if (busy && selb && !sela && ({selb, sela, dac} != prev_sd))
            trials.push_back(int'(dac));
        prev_sd <= {selb, sela, dac};
    end

    always @(negedge clk) begin
        if (snd_mon) begin
`ifdef DAC_SCAN_MUTE_EN
            if (snden !== (snden_in & ~busy)) snd_bad++;
`else
            if (snden !== snden_in) snd_bad++;
`endif
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_axis(input int j);
        return (j == 0) ? 0 : j - 1;
    endfunction

    // Binary search over the 6-bit code: keep each bit the joystick beats.
    task automatic exp_trials(input int j, output int seq[6]);
        int r = 0;
        for (int b = 5; b >= 0; b--) begin
            int t = r | (1 << b);
            seq[5 - b] = t;
            if (j > t) r = t;
        end
    endtask

    task automatic do_scan(input int cpu_at, input int exp_dac, input int exp_sel);
        int done_at = -1;
        int busy_cnt = 0;
        int a2_pre = -1;
        int a2_post = -1;
        int old_a2;
        int seq[6];
        old_a2 = int'(axis2);
        trials.delete();
        @(negedge clk) scan_req = 1'b1;
        @(posedge clk); #1 scan_req = 1'b0;
        check("start_busy", int'(busy), 1);
        check("start_dac", int'(dac), 32);
        if (busy) busy_cnt++;
        for (int k = 1; k <= SCAN + 4; k++) begin
            if (k == cpu_at) begin
                cpu_dac_we = 1'b1; cpu_dac = 6'd17;
                cpu_sel_we = 1'b1; cpu_selb = 1'b1; cpu_sela = 1'b0;
            end
            @(posedge clk); #1;
            cpu_dac_we = 1'b0; cpu_sel_we = 1'b0;
            if (k == 18 * (S + 1) - 1) a2_pre = int'(axis2);
            if (k == 18 * (S + 1))     a2_post = int'(axis2);
            if (done_at >= 0) begin
                check("done_width", int'(done), 0);
                break;
            end
            if (busy) busy_cnt++;
            if (done) done_at = k;
        end
        check("done_at", done_at, SCAN);
        check("busy_cycles", busy_cnt, SCAN);
        check("axis0", int'(axis0), exp_axis(int'(joy[0])));
        check("axis1", int'(axis1), exp_axis(int'(joy[1])));
        check("axis2", int'(axis2), exp_axis(int'(joy[2])));
        check("axis3", int'(axis3), exp_axis(int'(joy[3])));
        check("axis2_before_update", a2_pre, old_a2);
        check("axis2_at_update", a2_post, exp_axis(int'(joy[2])));
        exp_trials(int'(joy[2]), seq);
        check("trial_count", trials.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("trial%0d", i), (i < trials.size()) ? trials[i] : -1, seq[i]);
        check("restored_dac", int'(dac), exp_dac);
        check("restored_sel", int'({selb, sela}), exp_sel);
    endtask

    initial begin
        int d1, d2, cyc, dcount, bcount;
        joy[0] = 6'd0; joy[1] = 6'd1; joy[2] = 6'd40; joy[3] = 6'd63;
        #2 reset_n = 1'b0;
        snden_in = 1'b1;
        #10;
        check("rst_dac", int'(dac), 0);
        check("rst_sel", int'({selb, sela}), 0);
        check("rst_snden", int'(snden), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_axes", int'({axis0, axis1, axis2, axis3}), 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1 snd_mon = 1'b1;

        // Idle passthrough
        cpu_dac_we = 1'b1; cpu_dac = 6'd45;
        cpu_sel_we = 1'b1; cpu_selb = 1'b0; cpu_sela = 1'b1;
        @(posedge clk); #1;
        cpu_dac_we = 1'b0; cpu_sel_we = 1'b0; cpu_dac = 6'd3;
        check("idle_dac", int'(dac), 45);
        check("idle_sel", int'({selb, sela}), 1);
        check("idle_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 check("idle_hold_dac", int'(dac), 45);

        // Directed full scan, then a scan with CPU writes at cycle 10
        do_scan(0, 45, 1);
        do_scan(10, 17, 2);

        // Random joystick positions
        for (int n = 0; n < 4; n++) begin
            for (int a = 0; a < 4; a++) joy[a] = 6'($urandom_range(0, 63));
            do_scan(0, 17, 2);
        end

        // Back-to-back scans with scan_req held high
        d1 = -1; d2 = -1;
        @(negedge clk) scan_req = 1'b1;
        for (int k = 0; k < 3 * SCAN; k++) begin
            @(posedge clk); #1;
            if (done) begin
                if (d1 < 0) d1 = k;
                else begin
                    d2 = k;
                    scan_req = 1'b0;
                    break;
                end
            end
        end
        scan_req = 1'b0;
        check("b2b_seen", int'(d2 >= 0), 1);
        check("b2b_spacing", d2 - d1, SCAN + 1);
        @(posedge clk); #1 check("b2b_stop_busy", int'(busy), 0);

        check("snden_during_scans", snd_bad, 0);

        // Reset in the middle of a scan
        joy[0] = 6'd50; joy[1] = 6'd50; joy[2] = 6'd50; joy[3] = 6'd50;
        @(negedge clk) scan_req = 1'b1;
        @(posedge clk); #1 scan_req = 1'b0;
        repeat (40) @(posedge clk);
        #1 snd_mon = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_dac", int'(dac), 0);
        check("mid_rst_sel", int'({selb, sela}), 0);
        check("mid_rst_snden", int'(snden), 0);
        check("mid_rst_axes", int'({axis0, axis1, axis2, axis3}), 0);
        @(negedge clk) reset_n = 1'b1;
        dcount = 0; bcount = 0;
        for (cyc = 0; cyc < 100; cyc++) begin
            @(posedge clk); #1;
            if (done) dcount++;
            if (busy) bcount++;
        end
        check("post_rst_done", dcount, 0);
        check("post_rst_busy", bcount, 0);
        check("post_rst_snden", int'(snden), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
